// File: rtl/vec_pkg.sv
// Shared constants and types for the vector writeback stage.
package vec_pkg;

  localparam int unsigned N  = 24;
  localparam int unsigned M  = 6;
  localparam int unsigned RW = 5;

  localparam logic [3:0] SEL_SIN = 4'd8;
  localparam logic [3:0] SEL_COS = 4'd9;

  typedef struct packed {
    logic [RW-1:0]  rd;
    logic [M*N-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    S_IDLE,
    S_ROM
  } wb_state_t;

  function automatic logic is_trig(input logic [3:0] sel);
    return (sel == SEL_SIN) || (sel == SEL_COS);
  endfunction

endpackage

// File: rtl/vec_skid_fifo.sv
// Two-entry shifting FIFO of writeback entries; slot 0 is always the head.
// With VEC_WB_FWD_EN defined the second slot is exported for bypass.
module vec_skid_fifo
  import vec_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  logic      pop_i,
  input  wb_entry_t push_entry_i,
  output logic [1:0] count_o,
  output wb_entry_t head_o
`ifdef VEC_WB_FWD_EN
  ,
  output wb_entry_t tail_o
`endif
);

  wb_entry_t  slot0_q, slot0_d;
  wb_entry_t  slot1_q, slot1_d;
  logic [1:0] count_q, count_d;
  logic       pop_en;
  logic       push_en;

  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    pop_en  = pop_i && (count_q != 2'd0);
    push_en = push_i && ((count_q != 2'd2) || pop_en);

    if (pop_en && (count_q == 2'd2)) begin
      slot0_d = slot1_q;
    end
    // Slot 0 is left untouched on the last pop so the head holds its value.
    if (push_en) begin
      if ((count_q == 2'd0) || (pop_en && (count_q == 2'd1))) begin
        slot0_d = push_entry_i;
      end else begin
        slot1_d = push_entry_i;
      end
    end

    count_d = count_q + {1'b0, push_en} - {1'b0, pop_en};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      count_q <= 2'd0;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = slot0_q;
`ifdef VEC_WB_FWD_EN
  assign tail_o  = slot1_q;
`endif

endmodule

// File: rtl/vec_wb_stage.sv
// Execute-to-writeback stage: aligns the ROM cycle of sin/cos ops and buffers results.
// Optional macro VEC_WB_FWD_EN exports both FIFO entries for operand bypass.
module vec_wb_stage
  import vec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [3:0]          ex_select,
  input  logic [RW-1:0]       ex_rd,
  input  logic                ex_we,
  input  logic [M*N-1:0]      ex_result,
  output logic                wb_valid,
  input  logic                wb_ready,
  output logic [RW-1:0]       wb_rd,
  output logic [M*N-1:0]      wb_data
`ifdef VEC_WB_FWD_EN
  ,
  output logic [1:0]          fwd_valid,
  output logic [2*RW-1:0]     fwd_rd,
  output logic [2*M*N-1:0]    fwd_data
`endif
);

  wb_state_t     state_q, state_d;
  logic [RW-1:0] rom_rd_q, rom_rd_d;
  logic [1:0]    count;
  logic          push;
  wb_entry_t     push_entry;
  wb_entry_t     head;
`ifdef VEC_WB_FWD_EN
  wb_entry_t     tail;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rom_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      rom_rd_q <= rom_rd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    rom_rd_d = rom_rd_q;
    unique case (state_q)
      S_IDLE: begin
        if (ex_valid && ex_ready && ex_we && is_trig(ex_select)) begin
          state_d  = S_ROM;
          rom_rd_d = ex_rd;
        end
      end
      S_ROM:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // A trig op is only accepted with count<2 and nothing else enters during S_ROM,
  // so its slot is guaranteed free when the ROM data arrives.
  always_comb begin
    ex_ready         = (state_q == S_IDLE) && (count != 2'd2);
    push             = 1'b0;
    push_entry.rd    = ex_rd;
    push_entry.data  = ex_result;
    unique case (state_q)
      S_IDLE: push = ex_valid && ex_ready && ex_we && !is_trig(ex_select);
      S_ROM: begin
        push          = 1'b1;
        push_entry.rd = rom_rd_q;
      end
      default: push = 1'b0;
    endcase
  end

  vec_skid_fifo u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .pop_i        (wb_ready),
    .push_entry_i (push_entry),
    .count_o      (count),
    .head_o       (head)
`ifdef VEC_WB_FWD_EN
    ,
    .tail_o       (tail)
`endif
  );

  assign wb_valid = (count != 2'd0);
  assign wb_rd    = head.rd;
  assign wb_data  = head.data;

`ifdef VEC_WB_FWD_EN
  assign fwd_valid = {count == 2'd2, count != 2'd0};
  assign fwd_rd    = {tail.rd, head.rd};
  assign fwd_data  = {tail.data, head.data};
`endif

endmodule

// File: tb/tb_vec_wb_stage.sv
// Self-checking bench for vec_wb_stage: directed vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_vec_wb_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ex_valid = 1'b0;
  logic         ex_ready;
  logic [3:0]   ex_select = 4'd0;
  logic [4:0]   ex_rd = 5'd0;
  logic         ex_we = 1'b0;
  logic [143:0] ex_result = '0;
  logic         wb_valid;
  logic         wb_ready = 1'b0;
  logic [4:0]   wb_rd;
  logic [143:0] wb_data;

  int checks = 0;
  int errors = 0;

  vec_wb_stage dut (
    .clk       (clk),
    .rst       (rst),
    .ex_valid  (ex_valid),
    .ex_ready  (ex_ready),
    .ex_select (ex_select),
    .ex_rd     (ex_rd),
    .ex_we     (ex_we),
    .ex_result (ex_result),
    .wb_valid  (wb_valid),
    .wb_ready  (wb_ready),
    .wb_rd     (wb_rd),
    .wb_data   (wb_data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [143:0] lanes(input int base);
    logic [143:0] r;
    for (int k = 0; k < 6; k++) r[k*24 +: 24] = 24'(base + k);
    return r;
  endfunction

  // Reference model: ordered list of pending writebacks plus an outstanding trig op.
  typedef struct packed {
    logic [4:0]   rd;
    logic [143:0] data;
  } ent_t;

  ent_t       m_q[$];
  logic       m_pend;
  logic [4:0] m_prd;
  ent_t       m_last;
  logic [4:0] popped[$];

  task automatic model_reset();
    m_q.delete();
    m_pend = 1'b0;
    m_prd  = '0;
    m_last = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    popped.delete();
  endtask

  // Compare DUT against the model for the current cycle, then advance one clock.
  task automatic tick();
    logic exp_rdy;
    ent_t head;
    exp_rdy = !m_pend && (m_q.size() < 2);
    head    = (m_q.size() != 0) ? m_q[0] : m_last;
    check("ex_ready", 144'(ex_ready), 144'(exp_rdy));
    check("wb_valid", 144'(wb_valid), 144'(m_q.size() != 0));
    check("wb_rd", 144'(wb_rd), 144'(head.rd));
    check("wb_data", wb_data, head.data);
    if (wb_valid && wb_ready) popped.push_back(wb_rd);
    if ((m_q.size() != 0) && wb_ready) begin
      m_last = m_q[0];
      void'(m_q.pop_front());
    end
    if (m_pend) begin
      m_q.push_back('{rd: m_prd, data: ex_result});
      m_pend = 1'b0;
    end else if (ex_valid && exp_rdy && ex_we) begin
      if (ex_select == 4'd8 || ex_select == 4'd9) begin
        m_pend = 1'b1;
        m_prd  = ex_rd;
      end else begin
        m_q.push_back('{rd: ex_rd, data: ex_result});
      end
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         v;
    logic [3:0]   sel;
    logic         we;
    logic [4:0]   rd;
    logic [143:0] res;
    logic         wbr;
    logic         e_rdy;
    logic         e_wbv;
    logic [4:0]   e_rd;
    logic [143:0] e_data;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int acc_n;
    logic acc;

    // Non-trig op, then trig op with ROM data, then a discarded op.
    tbl[0] = '{1'b1, 4'd0, 1'b1, 5'd3, lanes(1),   1'b1, 1'b1, 1'b0, 5'd0, '0};
    tbl[1] = '{1'b0, 4'd0, 1'b1, 5'd0, '0,         1'b1, 1'b1, 1'b1, 5'd3, lanes(1)};
    tbl[2] = '{1'b0, 4'd0, 1'b1, 5'd0, '0,         1'b1, 1'b1, 1'b0, 5'd3, lanes(1)};
    tbl[3] = '{1'b1, 4'd8, 1'b1, 5'd7, lanes(100), 1'b1, 1'b1, 1'b0, 5'd3, lanes(1)};
    tbl[4] = '{1'b1, 4'd8, 1'b1, 5'd7, lanes(200), 1'b1, 1'b0, 1'b0, 5'd3, lanes(1)};
    tbl[5] = '{1'b0, 4'd0, 1'b1, 5'd0, '0,         1'b1, 1'b1, 1'b1, 5'd7, lanes(200)};
    tbl[6] = '{1'b0, 4'd0, 1'b1, 5'd0, '0,         1'b1, 1'b1, 1'b0, 5'd7, lanes(200)};
    tbl[7] = '{1'b1, 4'd0, 1'b0, 5'd9, lanes(300), 1'b1, 1'b1, 1'b0, 5'd7, lanes(200)};
    tbl[8] = '{1'b0, 4'd0, 1'b1, 5'd0, '0,         1'b1, 1'b1, 1'b0, 5'd7, lanes(200)};
    tbl[9] = '{1'b0, 4'd0, 1'b1, 5'd0, '0,         1'b1, 1'b1, 1'b0, 5'd7, lanes(200)};

    do_reset();
    for (int i = 0; i < 10; i++) begin
      ex_valid  = tbl[i].v;
      ex_select = tbl[i].sel;
      ex_we     = tbl[i].we;
      ex_rd     = tbl[i].rd;
      ex_result = tbl[i].res;
      wb_ready  = tbl[i].wbr;
      #1;
      check($sformatf("tbl%0d_ex_ready", i), 144'(ex_ready), 144'(tbl[i].e_rdy));
      check($sformatf("tbl%0d_wb_valid", i), 144'(wb_valid), 144'(tbl[i].e_wbv));
      check($sformatf("tbl%0d_wb_rd", i), 144'(wb_rd), 144'(tbl[i].e_rd));
      check($sformatf("tbl%0d_wb_data", i), wb_data, tbl[i].e_data);
      @(posedge clk);
      #1;
    end

    // Backpressure: two accepts fill the FIFO, third waits for wb_ready.
    do_reset();
    ex_valid = 1'b0; ex_we = 1'b1; ex_select = 4'd0; wb_ready = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      ex_valid  = 1'b1;
      ex_rd     = 5'(n);
      ex_result = lanes(n * 10);
      if (n == 3) begin
        check("bp_ready_low", 144'(ex_ready), 144'(0));
        tick();
        wb_ready = 1'b1;
      end
      acc = 1'b0;
      for (int t = 0; t < 10 && !acc; t++) begin
        acc = ex_ready;
        tick();
      end
      check($sformatf("bp_accept%0d", n), 144'(acc), 144'(1));
    end
    ex_valid = 1'b0;
    for (int t = 0; t < 5; t++) tick();
    check("bp_pop_count", 144'(popped.size()), 144'(3));
    for (int n = 0; n < 3 && n < popped.size(); n++)
      check($sformatf("bp_order%0d", n), 144'(popped[n]), 144'(n + 1));

    // Back-to-back ops with wb_ready high: one op per cycle.
    do_reset();
    wb_ready = 1'b1; ex_we = 1'b1; ex_select = 4'd0; ex_valid = 1'b1;
    acc_n = 0;
    for (int i = 0; i < 8; i++) begin
      ex_rd     = 5'(i + 16);
      ex_result = lanes(i * 7);
      if (ex_ready) acc_n++;
      tick();
    end
    ex_valid = 1'b0;
    tick();
    tick();
    check("tput_accepts", 144'(acc_n), 144'(8));
    check("tput_pops", 144'(popped.size()), 144'(8));

    // Reset while in the ROM cycle discards the trig op.
    do_reset();
    ex_valid = 1'b1; ex_select = 4'd9; ex_we = 1'b1; ex_rd = 5'd12; ex_result = lanes(400);
    tick();
    ex_result = lanes(500);
    check("rom_ready_low", 144'(ex_ready), 144'(0));
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
    popped.delete();
    ex_valid = 1'b0;
    #1;
    check("rst_rom_wb_valid", 144'(wb_valid), 144'(0));
    check("rst_rom_ex_ready", 144'(ex_ready), 144'(1));
    for (int t = 0; t < 4; t++) tick();
    check("rst_rom_no_emit", 144'(popped.size()), 144'(0));

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ex_valid  = ($urandom % 4) != 0;
      ex_select = (($urandom % 4) == 0) ? 4'(8 + ($urandom % 2)) : 4'($urandom % 8);
      ex_we     = ($urandom % 5) != 0;
      ex_rd     = 5'($urandom);
      ex_result = 144'({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()});
      wb_ready  = ($urandom % 3) != 0;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
